// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for the register file's single write port.
// Port A (ALU result) and port B (load result) each feed a one-entry buffer;
// buffered requests are granted round-robin onto registered write-port outputs.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [3:0]            a_dest,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [3:0]            b_dest,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  load_enable,
  output logic [3:0]            decoder_control,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_src,
  output logic                  busy
);

  localparam int unsigned DEST_W = 4;

  // Buffered write request: destination register and its data.
  typedef struct packed {
    logic [DEST_W-1:0]     dest;
    logic [DATA_WIDTH-1:0] data;
  } wr_entry_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  wr_entry_t a_buf;
  wr_entry_t b_buf;
  logic      a_full;
  logic      b_full;
  logic      rr_ptr;

  logic      grant_a_c;
  logic      grant_b_c;
  logic      a_load_c;
  logic      b_load_c;
  wr_entry_t grant_entry_c;

  // Grant selection: a lone full buffer wins; both full defers to rr_ptr.
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (!reset && !stall) begin
      if (a_full && b_full) begin
        grant_a_c = (rr_ptr == SRC_A);
        grant_b_c = (rr_ptr == SRC_B);
      end else begin
        grant_a_c = a_full;
        grant_b_c = b_full;
      end
    end
  end

  // A buffer being drained this cycle can be refilled at the same edge.
  assign a_ready  = !reset && (!a_full || grant_a_c);
  assign b_ready  = !reset && (!b_full || grant_b_c);
  assign a_load_c = a_valid && a_ready;
  assign b_load_c = b_valid && b_ready;

  // Winner's payload for the output register.
  assign grant_entry_c = grant_b_c ? b_buf : a_buf;

  // Pending or in-flight write indication.
  assign busy = a_full || b_full || load_enable;

  // Port A holding buffer: reload takes priority over drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_full <= 1'b0;
      a_buf  <= '0;
    end else if (a_load_c) begin
      a_full <= 1'b1;
      a_buf  <= '{dest: a_dest, data: a_data};
    end else if (grant_a_c) begin
      a_full <= 1'b0;
    end
  end

  // Port B holding buffer: reload takes priority over drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_full <= 1'b0;
      b_buf  <= '0;
    end else if (b_load_c) begin
      b_full <= 1'b1;
      b_buf  <= '{dest: b_dest, data: b_data};
    end else if (grant_b_c) begin
      b_full <= 1'b0;
    end
  end

  // Round-robin pointer moves to the port that did not win.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= SRC_A;
    end else if (grant_a_c) begin
      rr_ptr <= SRC_B;
    end else if (grant_b_c) begin
      rr_ptr <= SRC_A;
    end
  end

  // Write-port register: strobe follows the grant, payload holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_enable     <= 1'b0;
      decoder_control <= '0;
      write_data      <= '0;
      write_src       <= SRC_A;
    end else if (grant_a_c || grant_b_c) begin
      load_enable     <= 1'b1;
      decoder_control <= grant_entry_c.dest;
      write_data      <= grant_entry_c.data;
      write_src       <= grant_b_c ? SRC_B : SRC_A;
    end else begin
      load_enable     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table plus
// hand-written sequences, with per-port scoreboard queues for write payloads.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_dest;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_dest;
  logic [31:0] b_data;
  logic        load_enable;
  logic [3:0]  decoder_control;
  logic [31:0] write_data;
  logic        write_src;
  logic        busy;

  regfile_write_arbiter #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .a_valid         (a_valid),
    .a_ready         (a_ready),
    .a_dest          (a_dest),
    .a_data          (a_data),
    .b_valid         (b_valid),
    .b_ready         (b_ready),
    .b_dest          (b_dest),
    .b_data          (b_data),
    .load_enable     (load_enable),
    .decoder_control (decoder_control),
    .write_data      (write_data),
    .write_src       (write_src),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        av;
    logic [3:0]  ad;
    logic [31:0] adat;
    logic        bv;
    logic [3:0]  bd;
    logic [31:0] bdat;
    logic        st;
    logic        e_ar;
    logic        e_br;
    logic        e_le;
    logic        e_src;
    logic [3:0]  e_dc;
    logic [31:0] e_wd;
    logic        e_busy;
  } vec_t;

  ent_t        qa[$];
  ent_t        qb[$];
  logic [31:0] rf[16];
  logic        ar_s;
  logic        br_s;
  int          checks;
  int          errors;
  vec_t        vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample readies, record accepts,
  // then after the edge retire any write against the scoreboard.
  task automatic cycle(input logic rst, input logic av, input logic [3:0] ad,
                       input logic [31:0] adat, input logic bv, input logic [3:0] bd,
                       input logic [31:0] bdat, input logic st);
    ent_t e;
    @(negedge clk);
    reset   = rst;
    stall   = st;
    a_valid = av;
    a_dest  = ad;
    a_data  = adat;
    b_valid = bv;
    b_dest  = bd;
    b_data  = bdat;
    #1;
    ar_s = a_ready;
    br_s = b_ready;
    if (!rst) begin
      if (av && ar_s) qa.push_back('{dest: ad, data: adat});
      if (bv && br_s) qb.push_back('{dest: bd, data: bdat});
    end
    @(posedge clk);
    #1;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else if (load_enable === 1'b1) begin
      rf[decoder_control] = write_data;
      if (write_src === 1'b0) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_a_unexpected: got write dest %0d data 0x%08h expected none", decoder_control, write_data);
        end else begin
          e = qa.pop_front();
          chk("sb_a_dest", 32'(decoder_control), 32'(e.dest));
          chk("sb_a_data", write_data, e.data);
        end
      end else begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_b_unexpected: got write dest %0d data 0x%08h expected none", decoder_control, write_data);
        end else begin
          e = qb.pop_front();
          chk("sb_b_dest", 32'(decoder_control), 32'(e.dest));
          chk("sb_b_data", write_data, e.data);
        end
      end
    end
  endtask

  task automatic idle(input logic st);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, st);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    stall   = 1'b0;
    a_valid = 1'b1;
    a_dest  = 4'd1;
    a_data  = 32'h1;
    b_valid = 1'b1;
    b_dest  = 4'd2;
    b_data  = 32'h2;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;

    //            av  ad     adat          bv  bd     bdat   st  ar br le src dc     wd            busy
    vecs[0]  = '{1, 4'd3,  32'h11,       1, 4'd3, 32'h22, 0, 1, 1, 0, 0, 4'd0,  32'h0,        1};
    vecs[1]  = '{0, 4'd0,  32'h0,        0, 4'd0, 32'h0,  0, 1, 0, 1, 0, 4'd3,  32'h11,       1};
    vecs[2]  = '{0, 4'd0,  32'h0,        0, 4'd0, 32'h0,  0, 1, 1, 1, 1, 4'd3,  32'h22,       1};
    vecs[3]  = '{0, 4'd0,  32'h0,        0, 4'd0, 32'h0,  0, 1, 1, 0, 1, 4'd3,  32'h22,       0};
    vecs[4]  = '{1, 4'd5,  32'hDEADBEEF, 0, 4'd0, 32'h0,  0, 1, 1, 0, 1, 4'd3,  32'h22,       1};
    vecs[5]  = '{0, 4'd0,  32'h0,        0, 4'd0, 32'h0,  0, 1, 1, 1, 0, 4'd5,  32'hDEADBEEF, 1};
    vecs[6]  = '{0, 4'd0,  32'h0,        0, 4'd0, 32'h0,  0, 1, 1, 0, 0, 4'd5,  32'hDEADBEEF, 0};
    vecs[7]  = '{0, 4'd0,  32'h0,        1, 4'd0, 32'h1,  0, 1, 1, 0, 0, 4'd5,  32'hDEADBEEF, 1};
    vecs[8]  = '{0, 4'd0,  32'h0,        0, 4'd0, 32'h0,  0, 1, 1, 1, 1, 4'd0,  32'h1,        1};
    vecs[9]  = '{1, 4'd15, 32'hFFFFFFFF, 0, 4'd0, 32'h0,  0, 1, 1, 0, 1, 4'd0,  32'h1,        1};
    vecs[10] = '{1, 4'd14, 32'h12345678, 0, 4'd0, 32'h0,  0, 1, 1, 1, 0, 4'd15, 32'hFFFFFFFF, 1};
    vecs[11] = '{0, 4'd0,  32'h0,        0, 4'd0, 32'h0,  0, 1, 1, 1, 0, 4'd14, 32'h12345678, 1};
    vecs[12] = '{0, 4'd0,  32'h0,        0, 4'd0, 32'h0,  0, 1, 1, 0, 0, 4'd14, 32'h12345678, 0};

    // Reset held two cycles with both sources requesting.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 1'b0);
      chk($sformatf("rst%0d_a_ready", i), 32'(ar_s), 32'd0);
      chk($sformatf("rst%0d_b_ready", i), 32'(br_s), 32'd0);
    end
    chk("rst_load_enable", 32'(load_enable), 32'd0);
    chk("rst_decoder_control", 32'(decoder_control), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_write_src", 32'(write_src), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Vector table: same-destination pair, single writes, boundary registers.
    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, vecs[i].av, vecs[i].ad, vecs[i].adat, vecs[i].bv, vecs[i].bd, vecs[i].bdat, vecs[i].st);
      chk($sformatf("vec%0d_a_ready", i), 32'(ar_s), 32'(vecs[i].e_ar));
      chk($sformatf("vec%0d_b_ready", i), 32'(br_s), 32'(vecs[i].e_br));
      chk($sformatf("vec%0d_load_enable", i), 32'(load_enable), 32'(vecs[i].e_le));
      chk($sformatf("vec%0d_write_src", i), 32'(write_src), 32'(vecs[i].e_src));
      chk($sformatf("vec%0d_decoder_control", i), 32'(decoder_control), 32'(vecs[i].e_dc));
      chk($sformatf("vec%0d_write_data", i), write_data, vecs[i].e_wd);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
    end
    chk("same_dest_r3_final", rf[3], 32'h22);

    // Saturation from a fresh round-robin state.
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      cycle(1'b0, (c <= 8), 4'(c), 32'hA000_0000 + 32'(c), (c <= 8), 4'(c), 32'hB000_0000 + 32'(c), 1'b0);
      if (c >= 2 && c <= 10) begin
        chk($sformatf("sat%0d_load_enable", c), 32'(load_enable), 32'd1);
        chk($sformatf("sat%0d_write_src", c), 32'(write_src), 32'((c - 2) % 2));
      end else begin
        chk($sformatf("sat%0d_load_enable", c), 32'(load_enable), 32'd0);
      end
    end
    chk("sat_drained", 32'(qa.size() + qb.size()), 32'd0);

    // Stall with port B holding a write to r15.
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'hA5A5A5A5, 1'b0);
    chk("stall_load_b_ready", 32'(br_s), 32'd1);
    for (int s = 0; s < 3; s++) begin
      idle(1'b1);
      chk($sformatf("stall%0d_b_ready", s), 32'(br_s), 32'd0);
      chk($sformatf("stall%0d_a_ready", s), 32'(ar_s), 32'd1);
      chk($sformatf("stall%0d_load_enable", s), 32'(load_enable), 32'd0);
      chk($sformatf("stall%0d_busy", s), 32'(busy), 32'd1);
    end
    idle(1'b0);
    chk("unstall_b_ready", 32'(br_s), 32'd1);
    chk("unstall_load_enable", 32'(load_enable), 32'd1);
    chk("unstall_decoder_control", 32'(decoder_control), 32'd15);
    chk("unstall_write_src", 32'(write_src), 32'd1);
    chk("unstall_write_data", write_data, 32'hA5A5A5A5);
    idle(1'b0);
    chk("unstall_done_load_enable", 32'(load_enable), 32'd0);

    // Reset pulse with both buffers full discards pending writes.
    cycle(1'b0, 1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88, 1'b0);
    chk("midrst_fill_busy", 32'(busy), 32'd1);
    cycle(1'b1, 1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88, 1'b0);
    chk("midrst_a_ready", 32'(ar_s), 32'd0);
    chk("midrst_b_ready", 32'(br_s), 32'd0);
    chk("midrst_load_enable", 32'(load_enable), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    idle(1'b0);
    chk("midrst_after_load_enable", 32'(load_enable), 32'd0);
    chk("midrst_after_busy", 32'(busy), 32'd0);
    cycle(1'b0, 1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 32'd0, 1'b0);
    chk("midrst_req_a_ready", 32'(ar_s), 32'd1);
    chk("midrst_req_load_enable", 32'(load_enable), 32'd0);
    idle(1'b0);
    chk("midrst_req_write_le", 32'(load_enable), 32'd1);
    chk("midrst_req_write_dc", 32'(decoder_control), 32'd9);
    chk("midrst_req_write_wd", write_data, 32'h99);
    idle(1'b0);
    chk("midrst_req_done_le", 32'(load_enable), 32'd0);
    chk("final_drained", 32'(qa.size() + qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
